// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller.
// Optional feature macro used by the top level: VEND_TIMEOUT_EN.
package vend_pkg;

    localparam int CREDIT_W = 4;
    localparam int LED_W = 7;
    localparam int LED_CREDIT_LSB = 0;
    localparam int LED_STATE_LSB = 4;
    localparam int LED_STATE_W = 3;

    localparam logic [2:0] NICKEL_VAL = 3'd1;
    localparam logic [2:0] DIME_VAL = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_e;

    typedef logic [CREDIT_W-1:0] credit_t;
    typedef logic [CREDIT_W:0]   credit_sum_t;
    typedef logic [7:0]          cyc_cnt_t;

    // Credit increment for the coin events seen in one cycle (0..3 nickels).
    function automatic logic [2:0] coin_inc(input logic nickel, input logic dime);
        logic [2:0] n_val;
        logic [2:0] d_val;
        n_val = nickel ? NICKEL_VAL : 3'd0;
        d_val = dime ? DIME_VAL : 3'd0;
        return n_val + d_val;
    endfunction

endpackage

// File: rtl/vend_edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// A held-high input yields exactly one single-cycle pulse.
module vend_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic pulse_r;

    // Synchroniser chain and registered edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            pulse_r <= sync2_r & ~prev_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending machine sequencing controller: coin credit, vend and change payout.
// Define VEND_TIMEOUT_EN to refund idle credit after TIMEOUT_CYCLES in ACCUM.
module vend_credit_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE       = 5,
    parameter int MAX_CREDIT  = 15,
    parameter int DISP_CYCLES = 4,
    parameter int CHG_GAP     = 2
`ifdef VEND_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             coin_n_i,
    input  logic             coin_d_i,
    input  logic             sel_i,
    input  logic             ret_i,
    output logic             dispense_o,
    output logic             change_o,
    output logic             reject_o,
    output logic             busy_o,
    output logic [3:0]       credit_o,
    output logic [LED_W-1:0] led_o
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_ACCUM  = ST_ACCUM;
    localparam logic [1:0] S_VEND   = ST_VEND;
    localparam logic [1:0] S_CHANGE = ST_CHANGE;

    localparam credit_sum_t MAX_C     = credit_sum_t'(MAX_CREDIT);
    localparam credit_t     PRICE_C   = credit_t'(PRICE);
    localparam cyc_cnt_t    DISP_LAST = cyc_cnt_t'(DISP_CYCLES - 1);
    localparam cyc_cnt_t    GAP_LAST  = cyc_cnt_t'(CHG_GAP - 1);

    logic nick_ev_s;
    logic dime_ev_s;
    logic sel_ev_s;
    logic ret_ev_s;
    logic coin_s;

    logic [1:0]  state_r;
    logic [1:0]  state_s;
    credit_t     credit_r;
    credit_t     credit_s;
    credit_sum_t sum_s;
    cyc_cnt_t    disp_cnt_r;
    cyc_cnt_t    disp_cnt_s;
    cyc_cnt_t    gap_cnt_r;
    cyc_cnt_t    gap_cnt_s;
    logic        dispense_r;
    logic        dispense_s;
    logic        change_r;
    logic        change_s;
    logic        reject_r;
    logic        reject_s;
    logic        busy_r;
    logic        busy_s;
    logic [LED_W-1:0] led_s;

`ifdef VEND_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_cnt_r;
    logic [31:0] tmo_cnt_s;
`endif

    vend_edge_sync u_sync_nickel (.clk(clk), .rst_n(rst_n), .din(coin_n_i), .pulse(nick_ev_s));
    vend_edge_sync u_sync_dime   (.clk(clk), .rst_n(rst_n), .din(coin_d_i), .pulse(dime_ev_s));
    vend_edge_sync u_sync_sel    (.clk(clk), .rst_n(rst_n), .din(sel_i),    .pulse(sel_ev_s));
    vend_edge_sync u_sync_ret    (.clk(clk), .rst_n(rst_n), .din(ret_i),    .pulse(ret_ev_s));

    // Next-state, credit and output-pulse decode; ret beats sel beats coins.
    always_comb begin
        state_s    = state_r;
        credit_s   = credit_r;
        disp_cnt_s = disp_cnt_r;
        gap_cnt_s  = gap_cnt_r;
        dispense_s = 1'b0;
        change_s   = 1'b0;
        reject_s   = 1'b0;
        coin_s     = nick_ev_s | dime_ev_s;
        sum_s      = credit_sum_t'(credit_r) + credit_sum_t'(coin_inc(nick_ev_s, dime_ev_s));
`ifdef VEND_TIMEOUT_EN
        tmo_cnt_s  = 32'd0;
`endif
        case (state_r)
            S_IDLE, S_ACCUM: begin
                if (ret_ev_s && (credit_r != 4'd0)) begin
                    state_s   = S_CHANGE;
                    gap_cnt_s = 8'd0;
                    reject_s  = coin_s;
                end else if (sel_ev_s && (credit_r >= PRICE_C)) begin
                    state_s    = S_VEND;
                    credit_s   = credit_r - PRICE_C;
                    disp_cnt_s = DISP_LAST;
                    dispense_s = 1'b1;
                    reject_s   = coin_s;
                end else if (coin_s) begin
                    if (sum_s > MAX_C) begin
                        reject_s = 1'b1;
                    end else begin
                        credit_s = sum_s[CREDIT_W-1:0];
                        state_s  = S_ACCUM;
                    end
`ifdef VEND_TIMEOUT_EN
                end else if ((state_r == S_ACCUM) && (tmo_cnt_r == TMO_LAST)) begin
                    state_s   = S_CHANGE;
                    gap_cnt_s = 8'd0;
                end else if (state_r == S_ACCUM) begin
                    tmo_cnt_s = tmo_cnt_r + 32'd1;
`endif
                end else begin
                    state_s = state_r;
                end
            end
            S_VEND: begin
                reject_s = coin_s;
                if (disp_cnt_r != 8'd0) begin
                    disp_cnt_s = disp_cnt_r - 8'd1;
                    dispense_s = 1'b1;
                end else begin
                    state_s   = (credit_r != 4'd0) ? S_CHANGE : S_IDLE;
                    gap_cnt_s = 8'd0;
                end
            end
            S_CHANGE: begin
                reject_s = coin_s;
                // The last pulse is shown while still in CHANGE; leave on the next edge.
                if (credit_r == 4'd0) begin
                    state_s = S_IDLE;
                end else if (gap_cnt_r == 8'd0) begin
                    change_s  = 1'b1;
                    credit_s  = credit_r - 4'd1;
                    gap_cnt_s = GAP_LAST;
                end else begin
                    gap_cnt_s = gap_cnt_r - 8'd1;
                end
            end
            default: begin
                state_s  = S_IDLE;
                credit_s = 4'd0;
            end
        endcase
        busy_s = (state_s == S_VEND) || (state_s == S_CHANGE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            credit_r   <= 4'd0;
            disp_cnt_r <= 8'd0;
            gap_cnt_r  <= 8'd0;
            dispense_r <= 1'b0;
            change_r   <= 1'b0;
            reject_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            credit_r   <= credit_s;
            disp_cnt_r <= disp_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            dispense_r <= dispense_s;
            change_r   <= change_s;
            reject_r   <= reject_s;
            busy_r     <= busy_s;
        end
    end

`ifdef VEND_TIMEOUT_EN
    // Idle-credit timer; cleared outside ACCUM and on any accepted event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= 32'd0;
        end else begin
            tmo_cnt_r <= tmo_cnt_s;
        end
    end
`endif

    // LED status packing from the state and credit registers.
    always_comb begin
        led_s = '0;
        led_s[LED_STATE_LSB +: LED_STATE_W] = {1'b0, state_r};
        led_s[LED_CREDIT_LSB +: CREDIT_W]   = credit_r;
    end

    assign dispense_o = dispense_r;
    assign change_o   = change_r;
    assign reject_o   = reject_r;
    assign busy_o     = busy_r;
    assign credit_o   = credit_r;
    assign led_o      = led_s;

endmodule
